// File: rtl/uc_sequencer.sv
// uc_sequencer: opcode decode plus run/step/halt sequencer and retired-instruction counter; UC_ILLEGAL_TRAP_EN traps reserved opcodes
module uc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
`ifdef UC_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] retired
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] HALTED = 3'd3;
    localparam logic [2:0] SKIP   = 3'd4;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             exec, is_alu, is_li, is_halt, is_rsv, trap;
`ifdef UC_ILLEGAL_TRAP_EN
    logic             illegal_q, illegal_d;
    assign illegal = illegal_q;
`endif
    always_comb begin
        exec    = state_q == RUN || state_q == STEP;
        is_alu  = Opcode[5];
        is_li   = Opcode[5:2] == 4'b0000;
        is_halt = Opcode == 6'b000111;
        is_rsv  = !Opcode[5] && Opcode[4:3] != 2'b00;
`ifdef UC_ILLEGAL_TRAP_EN
        trap    = is_halt || is_rsv;
`else
        trap    = is_halt;
`endif
        pc_en   = (exec && !trap) || state_q == SKIP;
        we3     = exec && (is_alu || is_li);
        wez     = exec && is_alu;
        s_inm   = exec && is_li;
        Op      = exec && is_alu ? Opcode[4:2] : 3'b000;
        s_inc   = !exec                ? 1'b1 :
                  Opcode == 6'b000100  ? 1'b0 :
                  Opcode == 6'b000101  ? ~z   :
                  Opcode == 6'b000110  ? z    : 1'b1;
        running = exec;
        halted  = state_q == HALTED;
        retired = retired_q;
        state_d = state_q == IDLE   ? (start ? RUN : step ? STEP : IDLE) :
                  state_q == RUN    ? (trap ? HALTED : stop ? IDLE : RUN) :
                  state_q == STEP   ? (trap ? HALTED : IDLE) :
                  state_q == HALTED ? (start ? SKIP : HALTED) :
                  state_q == SKIP   ? RUN : IDLE;
        retired_d = exec && !trap && retired_q != {CNT_W{1'b1}} ? retired_q + 1'b1 : retired_q;
`ifdef UC_ILLEGAL_TRAP_EN
        illegal_d = exec && is_rsv ? 1'b1 :
                    state_q == HALTED && start ? 1'b0 : illegal_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            retired_q <= '0;
`ifdef UC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
`ifdef UC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end
endmodule
